player_anim_ctrl: RTL

- Sequences the frame select of the 9-frame player sprite ROM bank (frames 0-2 down, 3-5 side, 6-8 up) from joystick/movement requests.
- Runs a per-direction walk cycle paced by the video frame tick.
- Emits a horizontal-flip flag so the side frames serve both left and right.
- Sits between the player movement logic and the player sprite ROM bank in each player's render path.

---
 rtl/player_anim_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/player_anim_ctrl.sv
// Player sprite animation sequencer: picks the frame of the 9-frame sprite bank from movement requests.
// Optional build macro ANIM_RESTART_ON_TURN_EN restarts the walk cycle on stride A whenever the facing changes mid-walk.

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | standing pose base(dir), walk phase cleared, moving=0
// WALK  | walk cycle running; step advances every ANIM_DIV ticks, moving=1
module player_anim_ctrl #(
    parameter int NUM_FRAMES     = 9,
    parameter int FRAMES_PER_DIR = 3,
    parameter int ANIM_DIV       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          enable,
    input  logic                          move_up,
    input  logic                          move_down,
    input  logic                          move_left,
    input  logic                          move_right,
    output logic [$clog2(NUM_FRAMES)-1:0] frame,
    output logic                          flip_h,
    output logic [1:0]                    dir,
    output logic                          moving
);

    localparam int FW    = $clog2(NUM_FRAMES);
    localparam int DIV_W = $clog2(ANIM_DIV) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       step;
    logic [DIV_W-1:0] div;

    logic             any_req;
    logic [1:0]       res_dir;
    logic [1:0]       walk_step;
    logic [DIV_W-1:0] walk_div;

    function automatic logic [FW-1:0] base_of(input logic [1:0] d);
        case (d)
            DIR_DOWN: base_of = '0;
            DIR_UP:   base_of = FW'(2 * FRAMES_PER_DIR);
            default:  base_of = FW'(FRAMES_PER_DIR);
        endcase
    endfunction

    // Walk cycle: stand, stride A, stand, stride B.
    function automatic logic [FW-1:0] offset_of(input logic [1:0] s);
        case (s)
            2'd1:    offset_of = FW'(1);
            2'd3:    offset_of = FW'(2);
            default: offset_of = '0;
        endcase
    endfunction

    always_comb begin
        any_req = enable & (move_up | move_down | move_left | move_right);

        if (move_up)
            res_dir = DIR_UP;
        else if (move_down)
            res_dir = DIR_DOWN;
        else if (move_left)
            res_dir = DIR_LEFT;
        else
            res_dir = DIR_RIGHT;

        if (div == DIV_LAST) begin
            walk_div  = '0;
            walk_step = step + 2'd1;
        end else begin
            walk_div  = div + DIV_W'(1);
            walk_step = step;
        end

`ifdef ANIM_RESTART_ON_TURN_EN
        if (res_dir != dir) begin
            walk_div  = '0;
            walk_step = 2'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir    <= DIR_DOWN;
            step   <= 2'd0;
            div    <= '0;
            frame  <= '0;
            flip_h <= 1'b0;
            moving <= 1'b0;
        end else if (tick) begin
            if (!any_req) begin
                state  <= IDLE;
                step   <= 2'd0;
                div    <= '0;
                moving <= 1'b0;
                frame  <= base_of(dir);
                flip_h <= (dir == DIR_LEFT);
            end else begin
                case (state)
                    IDLE: begin
                        // First moving tick already shows stride A.
                        state  <= WALK;
                        dir    <= res_dir;
                        step   <= 2'd1;
                        div    <= '0;
                        moving <= 1'b1;
                        frame  <= base_of(res_dir) + offset_of(2'd1);
                        flip_h <= (res_dir == DIR_LEFT);
                    end
                    default: begin
                        state  <= WALK;
                        dir    <= res_dir;
                        step   <= walk_step;
                        div    <= walk_div;
                        moving <= 1'b1;
                        frame  <= base_of(res_dir) + offset_of(walk_step);
                        flip_h <= (res_dir == DIR_LEFT);
                    end
                endcase
            end
        end
    end

endmodule
